// File: rtl/axil_imem_slv_pkg.sv
// Shared definitions for the instruction-memory AXI-Lite read responder:
// response encodings, reset PC and the FSM state type.
package axil_imem_slv_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Core fetches its first instruction here; also the byte address of array word 0.
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StWait = 3'b010,
        StResp = 3'b100
    } state_e;

endpackage

// File: rtl/axil_imem_slv_imem_array.sv
// Word array with one synchronous read port and one write port. A same-edge
// read and write to one word returns the old data.
module axil_imem_slv_imem_array #(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              i_clr,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Output register doubles as the held R data; clear wins over a read.
    always_ff @(posedge clk_i) begin
        if (i_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axil_imem_slv.sv
// AXI-Lite read-only memory responder for instruction fetch, with configurable
// access latency and a backdoor write port for loading the program image.
module axil_imem_slv
    import axil_imem_slv_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH      = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = RESET_PC,
    parameter int unsigned       RD_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              slv_ar_valid_i,
    input  logic [ADDR_W-1:0] slv_ar_addr_i,
    output logic              slv_ar_ready_o,
    output logic              slv_r_valid_o,
    output logic [DATA_W-1:0] slv_r_data_o,
    output logic [1:0]        slv_r_resp_o,
    input  logic              slv_r_ready_i,
    input  logic              bd_we_i,
    input  logic [ADDR_W-1:0] bd_addr_i,
    input  logic [DATA_W-1:0] bd_data_i
);

    localparam int unsigned     IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT  = {1'b0, BASE_ADDR} + (ADDR_W + 1)'(DEPTH * 4);
    localparam logic [3:0]      LAT_M1 = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

    // Limit is one bit wider so the end of the window cannot wrap past zero.
    function automatic logic [1:0] f_decode(input logic [ADDR_W-1:0] a);
        if (a[1:0] != 2'b00) return AXI_RESP_SLVERR;
        if ((a < BASE_ADDR) || ({1'b0, a} >= LIMIT)) return AXI_RESP_DECERR;
        return AXI_RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] f_index(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    state_e            r_state;
    logic [3:0]        r_cnt;
    logic              r_ar_ready;
    logic              r_r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_resp;

    logic              w_ar_hs;
    logic              w_enter_resp;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [1:0]        w_rd_dec;
    logic              w_rd_err;
    logic              w_bd_ok;

    assign w_ar_hs  = slv_ar_valid_i & r_ar_ready;
    // With zero latency the array is read on the handshake edge itself.
    assign w_rd_addr = (r_state == StIdle) ? slv_ar_addr_i : r_addr;
    assign w_rd_dec  = f_decode(w_rd_addr);
    assign w_rd_err  = (w_rd_dec != AXI_RESP_OKAY);
    assign w_bd_ok   = bd_we_i & (f_decode(bd_addr_i) == AXI_RESP_OKAY);
    assign w_enter_resp = ((r_state == StIdle) && w_ar_hs && (RD_LATENCY == 0)) ||
                          ((r_state == StWait) && (r_cnt == 4'd0));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= StIdle;
            r_cnt      <= 4'd0;
            r_ar_ready <= 1'b1;
            r_r_valid  <= 1'b0;
            r_addr     <= '0;
            r_resp     <= AXI_RESP_OKAY;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_ar_hs) begin
                        r_addr     <= slv_ar_addr_i;
                        r_ar_ready <= 1'b0;
                        if (RD_LATENCY > 0) begin
                            r_state <= StWait;
                            r_cnt   <= LAT_M1;
                        end else begin
                            r_state   <= StResp;
                            r_r_valid <= 1'b1;
                            r_resp    <= w_rd_dec;
                        end
                    end
                end
                StWait: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= StResp;
                        r_r_valid <= 1'b1;
                        r_resp    <= w_rd_dec;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StResp: begin
                    if (slv_r_ready_i) begin
                        r_state    <= StIdle;
                        r_r_valid  <= 1'b0;
                        r_ar_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_ar_ready <= 1'b1;
                    r_r_valid  <= 1'b0;
                end
            endcase
        end
    end

    axil_imem_slv_imem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .i_clr   (rst_i | (w_enter_resp & w_rd_err)),
        .i_re    (w_enter_resp & ~w_rd_err),
        .i_raddr (f_index(w_rd_addr)),
        .o_rdata (slv_r_data_o),
        .i_we    (w_bd_ok),
        .i_waddr (f_index(bd_addr_i)),
        .i_wdata (bd_data_i)
    );

    assign slv_ar_ready_o = r_ar_ready;
    assign slv_r_valid_o  = r_r_valid;
    assign slv_r_resp_o   = r_resp;

endmodule

// File: tb/tb_axil_imem_slv.sv
// Bench for axil_imem_slv: four instances at latencies 1, 0, 4 and 2, compared
// against an array model of memory and the address-decode rules.
module tb_axil_imem_slv;

    localparam int          NI    = 4;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;

    function automatic int unsigned lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst      [NI];
    logic        ar_valid [NI];
    logic [31:0] ar_addr  [NI];
    logic        ar_ready [NI];
    logic        r_valid  [NI];
    logic [31:0] r_data   [NI];
    logic [1:0]  r_resp   [NI];
    logic        r_ready  [NI];
    logic        bd_we    [NI];
    logic [31:0] bd_addr  [NI];
    logic [31:0] bd_data  [NI];

    logic [31:0] mdl [NI][DEPTH];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        axil_imem_slv #(
            .RD_LATENCY (lat_of(g))
        ) u_dut (
            .clk_i          (clk),
            .rst_i          (rst[g]),
            .slv_ar_valid_i (ar_valid[g]),
            .slv_ar_addr_i  (ar_addr[g]),
            .slv_ar_ready_o (ar_ready[g]),
            .slv_r_valid_o  (r_valid[g]),
            .slv_r_data_o   (r_data[g]),
            .slv_r_resp_o   (r_resp[g]),
            .slv_r_ready_i  (r_ready[g]),
            .bd_we_i        (bd_we[g]),
            .bd_addr_i      (bd_addr[g]),
            .bd_data_i      (bd_data[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        longint unsigned la;
        la = a;
        if (a % 4 != 0) return 2'b10;
        if (la < longint'(BASE) || la >= longint'(BASE) + 4 * DEPTH) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_data(input int d, input logic [31:0] a);
        if (exp_resp(a) != 2'b00) return 32'h0;
        return mdl[d][(a - BASE) / 4];
    endfunction

    task automatic bd_write(input int d, input logic [31:0] a, input logic [31:0] v);
        bd_we[d] = 1'b1;
        bd_addr[d] = a;
        bd_data[d] = v;
        tick();
        bd_we[d] = 1'b0;
        if (exp_resp(a) == 2'b00) mdl[d][(a - BASE) / 4] = v;
    endtask

    // Runs one read; returns what the R beat carried and how long it took.
    task automatic read_txn(input int d, input logic [31:0] a, input int hold,
                            output logic [31:0] data, output logic [1:0] resp,
                            output int lat, output int start, output bit stable,
                            output bit timeout);
        int w;
        w = 0; data = '0; resp = '0; lat = 0; start = 0; stable = 1'b1; timeout = 1'b0;
        while (!ar_ready[d] && w < 50) begin
            tick();
            w++;
        end
        if (!ar_ready[d]) begin
            timeout = 1'b1;
            return;
        end
        start = int'(cyc);
        ar_valid[d] = 1'b1;
        ar_addr[d]  = a;
        r_ready[d]  = (hold == 0);
        tick();
        ar_valid[d] = 1'b0;
        lat = 1;
        while (!r_valid[d] && lat < 40) begin
            tick();
            lat++;
        end
        if (!r_valid[d]) begin
            timeout = 1'b1;
            r_ready[d] = 1'b0;
            return;
        end
        data = r_data[d];
        resp = r_resp[d];
        for (int i = 0; i < hold; i++) begin
            tick();
            if (r_valid[d] !== 1'b1 || r_data[d] !== data || r_resp[d] !== resp ||
                ar_ready[d] !== 1'b0) stable = 1'b0;
        end
        r_ready[d] = 1'b1;
        tick();
        r_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < NI; d++) begin
            rst[d] = 1'b1; ar_valid[d] = 1'b0; ar_addr[d] = '0; r_ready[d] = 1'b0;
            bd_we[d] = 1'b0; bd_addr[d] = '0; bd_data[d] = '0;
        end
        tick();
        tick();
        for (int d = 0; d < NI; d++) rst[d] = 1'b0;
        for (int d = 0; d < NI; d++) begin
            n_checks++;
            if (ar_ready[d] !== 1'b1 || r_valid[d] !== 1'b0 || r_data[d] !== 32'h0 ||
                r_resp[d] !== 2'b00) begin
                n_errors++;
                $display("FAIL reset[%0d]: got ar_ready=%b r_valid=%b data=%h resp=%b want 1 0 0 00",
                         d, ar_ready[d], r_valid[d], r_data[d], r_resp[d]);
            end
        end
    endtask

    task automatic test_preload();
        for (int d = 0; d < NI; d++) begin
            for (int i = 0; i < 16; i++) begin
                logic [31:0] v;
                v = $urandom;
                if (d == 0 && i == 0) v = 32'h0000_0413;
                if (d == 0 && i == 4) v = 32'h1111_1111;
                bd_write(d, BASE + 32'(4 * i), v);
            end
            bd_write(d, BASE + 32'(4 * (DEPTH - 1)), $urandom);
            // None of these may land anywhere in the array.
            bd_write(d, BASE + 32'h5, $urandom);
            bd_write(d, BASE + 32'(4 * DEPTH), $urandom);
            bd_write(d, BASE - 32'h4, $urandom);
        end
    endtask

    task automatic test_basic();
        logic [31:0] data; logic [1:0] resp; int lat, st; bit stb, to;
        read_txn(0, BASE, 0, data, resp, lat, st, stb, to);
        n_checks++;
        if (to || lat != 2) begin
            n_errors++;
            $display("FAIL basic_latency: got %0d (timeout=%0d) want 2", lat, to);
        end
        n_checks++;
        if (data !== 32'h0000_0413 || resp !== 2'b00) begin
            n_errors++;
            $display("FAIL basic_data: got %h/%b want 00000413/00", data, resp);
        end
        n_checks++;
        if (r_valid[0] !== 1'b0 || ar_ready[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_one_beat: got r_valid=%b ar_ready=%b want 0 1",
                     r_valid[0], ar_ready[0]);
        end
    endtask

    task automatic test_stall();
        logic [31:0] data; logic [1:0] resp; int lat, st; bit stb, to;
        read_txn(1, BASE + 32'hC, 5, data, resp, lat, st, stb, to);
        n_checks++;
        if (to || lat != 1) begin
            n_errors++;
            $display("FAIL stall_latency: got %0d (timeout=%0d) want 1", lat, to);
        end
        n_checks++;
        if (!stb) begin
            n_errors++;
            $display("FAIL stall_stable: got unstable R/ar_ready want stable");
        end
        n_checks++;
        if (data !== exp_data(1, BASE + 32'hC) || resp !== 2'b00) begin
            n_errors++;
            $display("FAIL stall_data: got %h/%b want %h/00", data, resp, exp_data(1, BASE + 32'hC));
        end
        n_checks++;
        if (r_valid[1] !== 1'b0 || ar_ready[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_idle: got r_valid=%b ar_ready=%b want 0 1", r_valid[1], ar_ready[1]);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        logic [31:0] data; logic [1:0] resp; int lat, st; bit stb, to;
        addrs[0] = 32'h8000_0002;
        addrs[1] = 32'h7FFF_FFFC;
        addrs[2] = 32'h8000_4000;
        addrs[3] = 32'h8000_3FFC;
        for (int i = 0; i < 4; i++) begin
            read_txn(1, addrs[i], i % 2, data, resp, lat, st, stb, to);
            n_checks++;
            if (to || resp !== exp_resp(addrs[i]) || data !== exp_data(1, addrs[i])) begin
                n_errors++;
                $display("FAIL decode %h: got %h/%b want %h/%b", addrs[i], data, resp,
                         exp_data(1, addrs[i]), exp_resp(addrs[i]));
            end
        end
    endtask

    task automatic test_same_edge();
        logic [31:0] a, old_v, data; logic [1:0] resp; int lat, st; bit stb, to;
        a = BASE + 32'h10;
        old_v = mdl[0][4];
        ar_valid[0] = 1'b1; ar_addr[0] = a; r_ready[0] = 1'b0;
        tick();
        ar_valid[0] = 1'b0;
        bd_write(0, a, 32'hDEAD_BEEF);
        n_checks++;
        if (r_valid[0] !== 1'b1 || r_data[0] !== old_v) begin
            n_errors++;
            $display("FAIL same_edge_old: got valid=%b data=%h want 1 %h", r_valid[0], r_data[0], old_v);
        end
        r_ready[0] = 1'b1;
        tick();
        r_ready[0] = 1'b0;
        read_txn(0, a, 0, data, resp, lat, st, stb, to);
        n_checks++;
        if (to || data !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL same_edge_new: got %h want deadbeef", data);
        end
        ar_valid[0] = 1'b1; ar_addr[0] = a;
        tick();
        ar_valid[0] = 1'b0;
        tick();
        bd_write(0, a, 32'h1234_5678);
        n_checks++;
        if (r_valid[0] !== 1'b1 || r_data[0] !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL held_after_write: got valid=%b data=%h want 1 deadbeef", r_valid[0], r_data[0]);
        end
        r_ready[0] = 1'b1;
        tick();
        r_ready[0] = 1'b0;
        read_txn(0, a, 0, data, resp, lat, st, stb, to);
        n_checks++;
        if (to || data !== exp_data(0, a)) begin
            n_errors++;
            $display("FAIL later_write: got %h want %h", data, exp_data(0, a));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] data; logic [1:0] resp; int lat, st; bit stb, to, stray;
        ar_valid[2] = 1'b1; ar_addr[2] = BASE + 32'h8; r_ready[2] = 1'b1;
        tick();
        ar_valid[2] = 1'b0;
        tick();
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        n_checks++;
        if (ar_ready[2] !== 1'b1 || r_valid[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_state: got ar_ready=%b r_valid=%b want 1 0", ar_ready[2], r_valid[2]);
        end
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (r_valid[2] !== 1'b0) stray = 1'b1;
            tick();
        end
        r_ready[2] = 1'b0;
        n_checks++;
        if (stray) begin
            n_errors++;
            $display("FAIL mid_reset_stray: got r_valid beat want none");
        end
        read_txn(2, BASE + 32'h8, 0, data, resp, lat, st, stb, to);
        n_checks++;
        if (to || lat != 5 || data !== exp_data(2, BASE + 32'h8) || resp !== 2'b00) begin
            n_errors++;
            $display("FAIL mid_reset_retain: got lat=%0d %h/%b want 5 %h/00", lat, data, resp,
                     exp_data(2, BASE + 32'h8));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data; logic [1:0] resp; int lat, st, prev; bit stb, to;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            read_txn(3, BASE + 32'(4 * i), 0, data, resp, lat, st, stb, to);
            n_checks++;
            if (to || data !== exp_data(3, BASE + 32'(4 * i)) || resp !== 2'b00 || lat != 3) begin
                n_errors++;
                $display("FAIL b2b_data[%0d]: got %h/%b lat=%0d want %h/00 lat=3", i, data, resp, lat,
                         exp_data(3, BASE + 32'(4 * i)));
            end
            if (i > 0) begin
                n_checks++;
                if (st - prev != 4) begin
                    n_errors++;
                    $display("FAIL b2b_period[%0d]: got %0d want 4", i, st - prev);
                end
            end
            prev = st;
        end
    endtask

    task automatic test_random();
        logic [31:0] a, data; logic [1:0] resp; int lat, st, hold; bit stb, to;
        for (int d = 0; d < NI; d++) begin
            for (int n = 0; n < 10; n++) begin
                case ($urandom_range(0, 3))
                    0, 1: a = BASE + 4 * $urandom_range(0, 15);
                    2:    a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
                    default: a = ($urandom_range(0, 1) == 0) ? BASE - 4 * $urandom_range(1, 100)
                                                             : BASE + 4 * DEPTH + 4 * $urandom_range(0, 100);
                endcase
                hold = $urandom_range(0, 3);
                read_txn(d, a, hold, data, resp, lat, st, stb, to);
                n_checks++;
                if (to || !stb || lat != int'(lat_of(d)) + 1 || data !== exp_data(d, a) ||
                    resp !== exp_resp(a)) begin
                    n_errors++;
                    $display("FAIL random[%0d] %h: got %h/%b lat=%0d stable=%0d want %h/%b lat=%0d",
                             d, a, data, resp, lat, stb, exp_data(d, a), exp_resp(a), lat_of(d) + 1);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_preload();
        test_basic();
        test_stall();
        test_errors();
        test_same_edge();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
